// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce block: prescaler divisor, ms-to-tick
// conversion and counter widths. Optional hold/repeat logic: DEBOUNCE_HOLD_EN.
package debounce_pkg;

    // Clock cycles per 1 ms tick.
    function automatic int prescale_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Filter/hold counters run on the 1 ms tick, so one tick per ms.
    function automatic int ms_to_ticks(input int ms);
        return ms;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-FF synchroniser, stable-time filter, edge pulses and,
// with DEBOUNCE_HOLD_EN defined, long-press / auto-repeat pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_noisy,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int DB_TICKS = ms_to_ticks(DEBOUNCE_MS);
    localparam int CW       = cnt_width(DB_TICKS);

    logic          r_s1, r_s2, r_clean, r_rise, r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_mismatch, w_flip, w_rise_nxt, w_fall_nxt;

    assign w_mismatch = (r_s2 != r_clean);
    assign w_flip     = w_mismatch && i_tick && (r_cnt == CW'(DB_TICKS - 1));
    assign w_rise_nxt = w_flip && !r_clean;
    assign w_fall_nxt = w_flip &&  r_clean;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_noisy;
            r_s2   <= r_s1;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            // Any agreement with the current level restarts the window.
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (w_flip) begin
                    r_clean <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_T = ms_to_ticks(HOLD_MS);
    localparam int REP_T  = ms_to_ticks(REPEAT_MS);
    localparam int HW     = cnt_width((HOLD_T > REP_T) ? HOLD_T : REP_T);

    logic [HW-1:0] r_hcnt;
    logic          r_rep, r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_rep  <= 1'b0;
            r_hold <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            // A release in progress wins over a hold due in the same cycle.
            if (!r_clean || w_fall_nxt) begin
                r_hcnt <= '0;
                r_rep  <= 1'b0;
            end else if (i_tick) begin
                if (!r_rep) begin
                    if (r_hcnt == HW'(HOLD_T - 1)) begin
                        r_hold <= 1'b1;
                        r_hcnt <= '0;
                        r_rep  <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end else if (REP_T > 0) begin
                    if (r_hcnt == HW'(REP_T - 1)) begin
                        r_hold <= 1'b1;
                        r_hcnt <= '0;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
            end
        end
    end

    assign o_hold = r_hold;
`else
    assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// N_CH-channel front-panel debouncer sharing one 1 ms tick prescaler.
// Long-press / auto-repeat pulses are built only with DEBOUNCE_HOLD_EN defined.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int N_CH        = 4,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] noisy,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    localparam int DIV = prescale_div(CLK_HZ);
    localparam int PW  = cnt_width(DIV - 1);

    if (CLK_HZ % 1000 != 0 || CLK_HZ < 1000) begin : g_bad_clk
        $error("debounce_array: CLK_HZ must be a multiple of 1000 and >= 1000");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_db
        $error("debounce_array: DEBOUNCE_MS must be >= 1");
    end
    if (N_CH < 1 || HOLD_MS < 1 || REPEAT_MS < 0) begin : g_bad_cfg
        $error("debounce_array: N_CH/HOLD_MS must be >= 1, REPEAT_MS >= 0");
    end

    logic [PW-1:0] r_pcnt;
    logic          w_tick;

    assign w_tick = (r_pcnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_pcnt <= '0;
        else if (w_tick) r_pcnt <= '0;
        else             r_pcnt <= r_pcnt + PW'(1);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
`ifdef DEBOUNCE_HOLD_EN
            ,
            .HOLD_MS     (HOLD_MS),
            .REPEAT_MS   (REPEAT_MS)
`endif
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_tick  (w_tick),
            .i_noisy (noisy[i]),
            .o_clean (clean[i]),
            .o_rise  (rise[i]),
            .o_fall  (fall[i]),
            .o_hold  (hold[i])
        );
    end

endmodule
